uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_pkg.sv | 43 ++++
 rtl/uart_rx_data_sampler.sv | 57 +++++
 rtl/uart_rx_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive frame controller: FSM state
// encoding, the legal oversampling ratios, and the sample/vote offsets
// measured from the middle of a bit (P/2).
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Offsets relative to P/2 at which each in-bit event happens.
  localparam int SMP_FIRST_OFS = -1;
  localparam int SMP_MID_OFS   = 0;
  localparam int SMP_LAST_OFS  = 1;
  localparam int VOTE_OFS      = 2;
  localparam int PAR_CAP_OFS   = 3;

  // Edge-counter value at which an event with offset ofs occurs for ratio p.
  function automatic logic [5:0] edge_at(input logic [5:0] p, input int ofs);
    return 6'(int'(p >> 1) + ofs);
  endfunction

  // An unsupported ratio is coerced to 16 so the edge counter always has a
  // well-defined wrap point and the sample offsets stay inside the bit.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_16;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_data_sampler
// Takes three samples of the serial line around the middle of each bit and
// forms their 2-of-3 majority.
//   clk, reset_n     : clock, asynchronous active-low reset
//   rx_i             : synchronized serial line
//   en_i             : high while a frame is being received
//   prescale_i       : latched oversampling ratio P
//   edge_cnt_i       : position inside the current bit, 0..P-1
//   vote_o           : majority of the three current samples (combinational)
//   sampled_bit_o    : registered vote, updated at P/2+2 and held
// -----------------------------------------------------------------------------
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  input  logic       en_i,
  input  logic [5:0] prescale_i,
  input  logic [5:0] edge_cnt_i,
  output logic       vote_o,
  output logic       sampled_bit_o
);

  logic [2:0] smp_q, smp_d;
  logic       sampled_q, sampled_d;

  assign vote_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign sampled_bit_o = sampled_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    smp_d     = smp_q;
    sampled_d = sampled_q;
    if (en_i) begin
      if (edge_cnt_i == edge_at(prescale_i, SMP_FIRST_OFS)) smp_d[0] = rx_i;
      if (edge_cnt_i == edge_at(prescale_i, SMP_MID_OFS))   smp_d[1] = rx_i;
      if (edge_cnt_i == edge_at(prescale_i, SMP_LAST_OFS))  smp_d[2] = rx_i;
      if (edge_cnt_i == edge_at(prescale_i, VOTE_OFS))      sampled_d = vote_o;
    end
  end

  // Samples reset to the idle line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_q     <= '1;
      sampled_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so all registers update from pre-edge values.
      smp_q     <= smp_d;
      sampled_q <= sampled_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// UART receive frame controller: detects the start edge, times each bit with
// an oversampling edge counter, deserializes DATA_WIDTH bits LSB first,
// handshakes with an external parity checker and reports the frame outcome.
//   clk, reset_n   : clock, asynchronous active-low reset
//   rx_in          : synchronized serial line, idle high
//   prescale       : oversampling ratio (8/16/32), latched at frame start
//   par_en         : frame carries a parity bit, latched at frame start
//   par_bit_error  : checker result, valid the cycle after par_chk_en
//   sampled_bit    : majority-voted value of the current bit
//   par_chk_en     : one-cycle enable to the parity checker
//   parallel_data  : last good frame's data
//   data_valid / par_error / stop_error : one-cycle frame-outcome pulses
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_bit_error,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [5:0]            p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic vote;
  logic at_last, at_vote, at_cap;

  assign at_last = (edge_cnt_q == p_q - 6'd1);
  assign at_vote = (edge_cnt_q == edge_at(p_q, VOTE_OFS));
  assign at_cap  = (edge_cnt_q == edge_at(p_q, PAR_CAP_OFS));

  uart_rx_data_sampler u_sampler (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_i          (rx_in),
    .en_i          (state_q != ST_IDLE),
    .prescale_i    (p_q),
    .edge_cnt_i    (edge_cnt_q),
    .vote_o        (vote),
    .sampled_bit_o (sampled_bit)
  );

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = at_last ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d  = bit_cnt_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    par_chk_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = '0;
        par_flag_d = 1'b0;
        p_d        = legal_prescale(prescale);
        par_en_d   = par_en;
        if (!rx_in) state_d = ST_START;
      end
      ST_START: begin
        // The vote for the start bit is registered by P/2+2, so it is stable here.
        if (at_last) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        // The fresh vote is used directly; sampled_bit only updates on this edge.
        if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (at_last) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_vote) par_chk_en = 1'b1;
        if (at_cap)  par_flag_d = par_bit_error;
        if (at_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave at mid-stop so a start edge half a bit later is not missed.
        if (at_vote) begin
          state_d    = ST_IDLE;
          edge_cnt_d = 6'd0;
          if (par_flag_q) begin
            pe_d = 1'b1;
          end else if (!vote) begin
            se_d = 1'b1;
          end else begin
            dv_d   = 1'b1;
            data_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      p_q        <= PRESCALE_16;
      par_en_q   <= 1'b0;
      // NOTE: the shift register is small flop storage, not a RAM, so it can
      // and does take the reset like every other register.
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      p_q        <= p_d;
      par_en_q   <= par_en_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign parallel_data = data_q;
  assign data_valid    = dv_q;
  assign par_error     = pe_q;
  assign stop_error    = se_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Bench for uart_rx_frame_ctrl. A frame-level model predicts, for each frame
// sent, which outcome pulse appears and in which cycle, plus the value held on
// parallel_data; a compare process checks all of them every cycle. A small
// parity-checker model answers par_chk_en with even-parity results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_in = 1'b1;
  logic [5:0]   prescale = 6'd8;
  logic         par_en = 1'b0;
  logic         par_bit_error = 1'b0;
  logic         sampled_bit, par_chk_en, data_valid, par_error, stop_error;
  logic [W-1:0] parallel_data;

  uart_rx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_in         (rx_in),
    .prescale      (prescale),
    .par_en        (par_en),
    .par_bit_error (par_bit_error),
    .sampled_bit   (sampled_bit),
    .par_chk_en    (par_chk_en),
    .parallel_data (parallel_data),
    .data_valid    (data_valid),
    .par_error     (par_error),
    .stop_error    (stop_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {EV_DV, EV_PE, EV_SE} ev_kind_e;
  typedef struct {
    ev_kind_e     kind;
    logic [W-1:0] data;
    logic         stop;
    int           at;
  } ev_t;

  ev_t          evq[$];
  ev_t          ev_now;
  logic [W-1:0] model_hold = '0;
  logic         e_dv, e_pe, e_se;
  bit           par_resp = 1'b0;
  int           n_checks = 0, n_fail = 0;
  int           dv_cnt = 0, pe_cnt = 0, se_cnt = 0, chk_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    check("rst_par_chk_en", 32'(par_chk_en), 32'd0);
    check("rst_parallel_data", 32'(parallel_data), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_error", 32'(par_error), 32'd0);
    check("rst_stop_error", 32'(stop_error), 32'd0);
  endtask

  // Drives one whole frame starting in the current cycle and records the
  // expected outcome. With the first low line cycle at s, stop-bit middle
  // evaluation plus the one-cycle registered pulse lands at
  // s + nstop*P + P/2 + 4, where nstop is the index of the stop bit.
  task automatic send_frame(input logic [W-1:0] d, input int p, input bit with_par,
                            input bit par_bit, input bit stop_bit);
    ev_t ev;
    int  nstop;
    nstop    = with_par ? W + 2 : W + 1;
    par_resp = ((^d) != par_bit);
    if (with_par && par_resp) ev.kind = EV_PE;
    else if (!stop_bit)       ev.kind = EV_SE;
    else                      ev.kind = EV_DV;
    ev.data = d;
    ev.stop = stop_bit;
    ev.at   = cyc + nstop * p + p / 2 + 4;
    evq.push_back(ev);
    rx_in = 1'b0;
    tick(p);
    for (int i = 0; i < W; i++) begin
      rx_in = d[i];
      tick(p);
    end
    if (with_par) begin
      rx_in = par_bit;
      tick(p);
    end
    rx_in = stop_bit;
    tick(p);
    rx_in = 1'b1;
  endtask

  // Parity checker model: answers in the cycle after par_chk_en.
  initial forever begin
    @(negedge clk);
    if (reset_n && par_chk_en) begin
      chk_cnt++;
      @(posedge clk);
      #1 par_bit_error = par_resp;
      @(posedge clk);
      #1 par_bit_error = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the frame model.
  always @(negedge clk) begin
    if (reset_n) begin
      e_dv = 1'b0;
      e_pe = 1'b0;
      e_se = 1'b0;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        ev_now = evq.pop_front();
        e_dv = (ev_now.kind == EV_DV);
        e_pe = (ev_now.kind == EV_PE);
        e_se = (ev_now.kind == EV_SE);
        if (e_dv) model_hold = ev_now.data;
        check("sampled_bit_at_stop", 32'(sampled_bit), 32'(ev_now.stop));
      end
      check("data_valid", 32'(data_valid), 32'(e_dv));
      check("par_error", 32'(par_error), 32'(e_pe));
      check("stop_error", 32'(stop_error), 32'(e_se));
      check("parallel_data", 32'(parallel_data), 32'(model_hold));
      if (data_valid) dv_cnt++;
      if (par_error)  pe_cnt++;
      if (stop_error) se_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] partial;
    partial = 8'hC3;

    tick(3);
    check_reset_values();
    reset_n = 1'b1;
    tick(4);

    // P=8, no parity, 0xA5; ratio and parity enable change mid-frame.
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      begin
        tick(30);
        prescale = 6'd16;
        par_en   = 1'b1;
      end
    join
    prescale = 6'd8;
    par_en   = 1'b0;
    tick(5);
    check("a5_value", 32'(parallel_data), 32'h0000_00A5);
    check("a5_dv_count", 32'(dv_cnt), 32'd1);
    check("a5_no_errors", 32'(pe_cnt + se_cnt), 32'd0);

    // P=16, three-cycle glitch, then 0x3C.
    prescale = 6'd16;
    tick(2);
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(30);
    check("glitch_no_pulse", 32'(dv_cnt + pe_cnt + se_cnt), 32'd1);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
    tick(5);
    check("3c_value", 32'(parallel_data), 32'h0000_003C);
    check("3c_dv_count", 32'(dv_cnt), 32'd2);

    // P=16 with parity: bad parity on 0x0F, then good parity on 0x0F.
    par_en = 1'b1;
    tick(2);
    send_frame(8'h0F, 16, 1'b1, 1'b1, 1'b1);
    tick(5);
    check("pe_chk_count", 32'(chk_cnt), 32'd1);
    check("pe_count", 32'(pe_cnt), 32'd1);
    check("pe_no_dv", 32'(dv_cnt), 32'd2);
    check("pe_data_held", 32'(parallel_data), 32'h0000_003C);
    send_frame(8'h0F, 16, 1'b1, 1'b0, 1'b1);
    tick(5);
    check("par_ok_chk_count", 32'(chk_cnt), 32'd2);
    check("par_ok_value", 32'(parallel_data), 32'h0000_000F);

    // P=8, 0x81 with a zero stop bit.
    par_en   = 1'b0;
    prescale = 6'd8;
    tick(2);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
    tick(5);
    check("se_count", 32'(se_cnt), 32'd1);
    check("se_no_dv", 32'(dv_cnt), 32'd3);
    check("se_data_held", 32'(parallel_data), 32'h0000_000F);

    // P=32, back-to-back frames with a one-bit stop.
    prescale = 6'd32;
    tick(2);
    send_frame(8'h11, 32, 1'b0, 1'b0, 1'b1);
    send_frame(8'hEE, 32, 1'b0, 1'b0, 1'b1);
    tick(5);
    check("b2b_dv_count", 32'(dv_cnt), 32'd5);
    check("b2b_last_value", 32'(parallel_data), 32'h0000_00EE);

    // P=16, reset in the middle of data bit 4, then 0x5A.
    prescale = 6'd16;
    tick(2);
    rx_in = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      tick(16);
    end
    rx_in = partial[4];
    tick(8);
    reset_n = 1'b0;
    #1;
    evq.delete();
    model_hold = '0;
    check_reset_values();
    rx_in = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1);
    tick(5);
    check("post_rst_value", 32'(parallel_data), 32'h0000_005A);
    check("post_rst_dv_count", 32'(dv_cnt), 32'd6);
    check("events_pending", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
